alu_multicycle: RTL

//   Parametrised successor of the single-cycle integer ALU. Registered result

---
 rtl/alu_multicycle.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Integer ALU with valid/ready handshakes: single-cycle logic/arith/shift ops plus
// iterative shift-add MUL and restoring DIVU/REMU running one step per cycle.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             busy
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLL  = 4'b1110;
    localparam logic [3:0] OP_SRL  = 4'b1111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [3:0]         op;
    // MUL: acc=partial product, a=multiplicand, b=multiplier.
    // DIVU/REMU: acc=partial remainder, a=dividend shifting into quotient, b=divisor.
    logic [WIDTH-1:0]   acc, a, b;

    logic [WIDTH-1:0]   mul_acc_nxt;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_nxt, div_quo_nxt;

    function automatic logic [WIDTH-1:0] alu_single(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic [3:0]       ctl);
        logic [SHAMT_W-1:0] sh;
        logic [WIDTH-1:0]   r;
        sh = y[SHAMT_W-1:0];
        case (ctl)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
            OP_NOR:  r = ~(x | y);
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = $signed(x) >>> sh;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_multi(input logic [3:0] ctl);
        return (ctl == OP_MUL) || (ctl == OP_DIVU) || (ctl == OP_REMU);
    endfunction

    always_comb begin
        mul_acc_nxt = acc + (b[0] ? a : '0);
        div_shift   = {acc, a[WIDTH-1]};
        div_ge      = (div_shift >= {1'b0, b});
        div_diff    = div_ge ? (div_shift - {1'b0, b}) : div_shift;
        div_rem_nxt = div_diff[WIDTH-1:0];
        div_quo_nxt = {a[WIDTH-2:0], div_ge};
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op         <= '0;
            alu_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_multi(alu_control)) begin
                            op    <= alu_control;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            alu_result <= alu_single(operand1, operand2, alu_control);
                            state      <= DONE;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SHAMT_W'(WIDTH - 1)) begin
                        if (op == OP_MUL)       alu_result <= mul_acc_nxt;
                        else if (op == OP_DIVU) alu_result <= div_quo_nxt;
                        else                    alu_result <= div_rem_nxt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Iteration datapath: loaded on accept, stepped once per BUSY cycle
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            acc <= '0;
            a   <= operand1;
            b   <= operand2;
        end else if (state == BUSY) begin
            if (op == OP_MUL) begin
                acc <= mul_acc_nxt;
                a   <= a << 1;
                b   <= b >> 1;
            end else begin
                acc <= div_rem_nxt;
                a   <= div_quo_nxt;
            end
        end
    end
endmodule
